// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults, word type and in-flight popcount helper for the FIFO stream reader.
package fifo_stream_pkg;

    localparam int DEFAULT_RD_LATENCY = 2;
    localparam int DEFAULT_BUF_DEPTH  = 4;

    typedef logic [31:0] word_t;

    // Up to four latency stages plus the capture stage are tracked.
    function automatic logic [2:0] popcount_lat(input logic [4:0] bits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 5; i++) begin
            n = n + {2'b00, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read side plus outgoing valid/ready stream; master is the reader, slave is FIFO+consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] FIFO_DOUT;
    logic                  FIFO_EMPTY;
    logic                  FIFO_ALMOST_EMPTY;
    logic                  FIFO_RD_EN;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic                  M_VALID;
    logic                  M_READY;

    modport master (
        input  FIFO_DOUT, FIFO_EMPTY, FIFO_ALMOST_EMPTY, M_READY,
        output FIFO_RD_EN, M_DATA, M_VALID
    );

    modport slave (
        output FIFO_DOUT, FIFO_EMPTY, FIFO_ALMOST_EMPTY, M_READY,
        input  FIFO_RD_EN, M_DATA, M_VALID
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Circular landing buffer; push and pop in the same cycle leave count unchanged.
// Zero-latency read of the head entry; caller must never push into a full buffer.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [$clog2(BUF_DEPTH):0]   count
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= din;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    overflow_chk: assert property (@(posedge CLK) disable iff (!RESET_N)
        !(push && !pop && (count_q == CW'(BUF_DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a fixed-latency FIFO into a credit-checked buffer and streams it out; optional WORD_CNT under FIFO_STREAM_READER_CNT_EN.
// First word: M_VALID rises RD_LATENCY+1 edges after the edge sampling FIFO_RD_EN; then 1 word/cycle. M_READY low stalls reads once buffer+in-flight fill.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
    parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    fifo_stream_reader_if.master  bus
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [31:0]           WORD_CNT
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [RD_LATENCY-1:0] inflight_sr_q;
    logic                  capture_q;
    logic                  rd_issued_q;
    logic                  rd_en;
    logic                  vld;
    logic                  pop;
    logic [CW-1:0]         count;
    logic [2:0]            n_inflight;
    logic [7:0]            committed;

    // capture_q is the cycle FIFO_DOUT actually holds the word, one stage past the latency shifter.
    assign n_inflight = popcount_lat(5'({capture_q, inflight_sr_q}));
    assign committed  = 8'(count) - 8'(pop) + 8'(n_inflight);

    // rd_issued_q covers the flag lag: the FIFO may already be empty while still showing almost-empty.
    assign rd_en = RESET_N & !bus.FIFO_EMPTY
                 & !(bus.FIFO_ALMOST_EMPTY & rd_issued_q)
                 & (committed < 8'(BUF_DEPTH));

    assign vld            = (count != '0);
    assign pop            = vld & bus.M_READY;
    assign bus.FIFO_RD_EN = rd_en;
    assign bus.M_VALID    = vld;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inflight_sr_q <= '0;
            capture_q     <= 1'b0;
            rd_issued_q   <= 1'b0;
        end else begin
            inflight_sr_q <= (inflight_sr_q << 1) | RD_LATENCY'(rd_en);
            capture_q     <= inflight_sr_q[RD_LATENCY-1];
            rd_issued_q   <= rd_en;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (capture_q),
        .din     (bus.FIFO_DOUT),
        .pop     (pop),
        .dout    (bus.M_DATA),
        .count   (count)
    );

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)  word_cnt_q <= '0;
        else if (pop)  word_cnt_q <= word_cnt_q + 32'd1;
    end

    assign WORD_CNT = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two-stage-latency FIFO model with lagging flags, scoreboard of expected words.
module tb_fifo_stream_reader;
    import fifo_stream_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(32)) bus ();

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [31:0] word_cnt;
`endif

    fifo_stream_reader dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
`ifdef FIFO_STREAM_READER_CNT_EN
        ,
        .WORD_CNT(word_cnt)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    word_t fifo_q[$];
    word_t exp_q[$];
    word_t s1, s2;

    // FIFO model: data valid two edges after the sampling edge, flags reflect the pre-edge occupancy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            exp_q.delete();
            s1 <= '0;
            s2 <= '0;
            bus.FIFO_DOUT         <= '0;
            bus.FIFO_EMPTY        <= 1'b1;
            bus.FIFO_ALMOST_EMPTY <= 1'b0;
        end else begin
            int sz;
            sz = fifo_q.size();
            bus.FIFO_EMPTY        <= (sz == 0);
            bus.FIFO_ALMOST_EMPTY <= (sz == 1);
            if (bus.FIFO_RD_EN) begin
                check("rd_nonempty", 32'(sz != 0), 32'd1);
                if (sz != 0) s1 <= fifo_q.pop_front();
            end
            s2 <= s1;
            bus.FIFO_DOUT <= s2;
        end
    end

    int    cyc = 0;
    int    rd_cnt, pop_cnt, vld_run, max_run, max_bcnt, first_rd, first_vld;
    bit    hold_p, stall_chk;
    word_t hold_d;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                check("hold_valid", 32'(bus.M_VALID), 32'd1);
                check("hold_data", bus.M_DATA, hold_d);
            end
            if (bus.FIFO_RD_EN) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.M_VALID) begin
                if (first_vld < 0) first_vld = cyc;
                vld_run++;
                if (vld_run > max_run) max_run = vld_run;
            end else begin
                vld_run = 0;
            end
            if (int'(dut.u_buf.count) > max_bcnt) max_bcnt = int'(dut.u_buf.count);
            if (stall_chk) check("stall_data", bus.M_DATA, 32'd0);
            if (bus.M_VALID && bus.M_READY) begin
                pop_cnt++;
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("beat_data", bus.M_DATA, exp_q.pop_front());
            end
            hold_p = bus.M_VALID && !bus.M_READY;
            hold_d = bus.M_DATA;
        end
    end

    task automatic clr_stats();
        rd_cnt = 0; pop_cnt = 0; vld_run = 0; max_run = 0;
        max_bcnt = 0; first_rd = -1; first_vld = -1;
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(word_t'(base + i));
            exp_q.push_back(word_t'(base + i));
        end
    endtask

    task automatic drain(input int lim, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.M_READY = 1'b0;
        clr_stats();
        stall_chk = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.M_VALID), 32'd0);
        check("rst_rden", 32'(bus.FIFO_RD_EN), 32'd0);
        check("rst_data", bus.M_DATA, 32'd0);
        rst_n = 1'b1;

        // Basic fill and drain
        @(posedge clk); #1;
        clr_stats();
        load(0, 256);
        bus.M_READY = 1'b1;
        drain(1000, "basic_drain");
        check("first_latency", 32'(first_vld - (first_rd + 1)), 32'd3);
        check("basic_pops", pop_cnt, 32'd256);
        check("basic_rds", rd_cnt, 32'd256);
        check("basic_run", max_run, 32'd256);
`ifdef FIFO_STREAM_READER_CNT_EN
        check("cnt_256", word_cnt, 32'd256);
`endif

        // Backpressure, M_READY toggling every cycle
        repeat (4) @(posedge clk);
        #1;
        clr_stats();
        load(1000, 16);
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
            bus.M_READY = ~bus.M_READY;
        end
        check("bp_left", exp_q.size(), 32'd0);
        check("bp_pops", pop_cnt, 32'd16);
        check("bp_rds", rd_cnt, 32'd16);
        check("bp_maxbuf_le4", 32'(max_bcnt <= 4), 32'd1);

        // Long stall from a clean buffer
        bus.M_READY = 1'b0;
        do_reset();
        clr_stats();
        load(0, 32);
        stall_chk = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        stall_chk = 1'b0;
        check("stall_rds", rd_cnt, 32'd4);
        check("stall_buf", 32'(dut.u_buf.count), 32'd4);
        bus.M_READY = 1'b1;
        drain(500, "stall_drain");
        check("stall_pops", pop_cnt, 32'd32);

        // Empty FIFO, then a single word
        repeat (4) @(posedge clk);
        #1;
        clr_stats();
        repeat (50) @(posedge clk);
        #1;
        check("empty_rds", rd_cnt, 32'd0);
        check("empty_vld", max_run, 32'd0);
        load(32'hA5, 1);
        repeat (20) @(posedge clk);
        #1;
        check("single_rds", rd_cnt, 32'd1);
        check("single_pops", pop_cnt, 32'd1);
        check("single_left", exp_q.size(), 32'd0);

        // Asynchronous reset with four words buffered
        bus.M_READY = 1'b0;
        clr_stats();
        load(200, 10);
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_buf", 32'(dut.u_buf.count), 32'd4);
        check("pre_rst_vld", 32'(bus.M_VALID), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.M_VALID), 32'd0);
        check("arst_rden", 32'(bus.FIFO_RD_EN), 32'd0);
        check("arst_count", 32'(dut.u_buf.count), 32'd0);
        check("arst_wrptr", 32'(dut.u_buf.wr_ptr_q), 32'd0);
        check("arst_rdptr", 32'(dut.u_buf.rd_ptr_q), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr_stats();
        load(300, 10);
        bus.M_READY = 1'b1;
        drain(200, "post_rst_drain");
        check("post_rst_pops", pop_cnt, 32'd10);

`ifdef FIFO_STREAM_READER_CNT_EN
        @(posedge clk); #1;
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.word_cnt_q;
        check("cnt_forced", word_cnt, 32'hFFFF_FFFF);
        load(77, 1);
        drain(50, "wrap_drain");
        @(posedge clk); #1;
        check("cnt_wrap", word_cnt, 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
